// File: rtl/kanagawa_fifo_read_prefetch.sv
// Prefetching read front-end: turns an empty/rdreq FIFO port with fixed-latency RAM into a valid/ready stream.
// Latency: empty_in low at t -> rdreq_out at t -> out_valid at t+READ_LATENCY+1 when the buffer is empty.
// Backpressure: reads are issued only while in-flight plus buffered words fit in OUT_DEPTH, so nothing is dropped.
module kanagawa_fifo_read_prefetch #(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 2,
    parameter int OUT_DEPTH    = 4,
    localparam int CW          = $clog2(OUT_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             rdreq_out,
    input  logic             empty_in,
    input  logic [WIDTH-1:0] rddata_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    if (OUT_DEPTH < 1 || READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_param_check
        $error("kanagawa_fifo_read_prefetch: OUT_DEPTH must be >= 1 and READ_LATENCY in 1..8");
    end

    logic [READ_LATENCY-1:0] inflight_sr;
    logic [3:0]              inflight_cnt;
    logic                    credit_ok;
    logic                    arrive;
    logic                    pop;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [WIDTH-1:0]        buf_mem [OUT_DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + {3'b000, inflight_sr[i]};
        end
    end

    // Credit uses registered state only; a pop this cycle frees space next cycle.
    assign credit_ok = (32'(inflight_cnt) + 32'(occupancy)) < 32'(OUT_DEPTH);
    assign rdreq_out = !empty_in && credit_ok && rst;
    assign arrive    = inflight_sr[READ_LATENCY-1];
    assign out_valid = (occupancy != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = buf_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_sr <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
        end else begin
            inflight_sr <= (inflight_sr << 1) | READ_LATENCY'(rdreq_out);
            if (arrive) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({arrive, pop})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (arrive) begin
            buf_mem[wr_ptr] <= rddata_in;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(arrive && (occupancy == CW'(OUT_DEPTH))))
        else $error("kanagawa_fifo_read_prefetch: word arrived while output buffer full");

endmodule

// File: tb/tb_kanagawa_fifo_read_prefetch.sv
// Bench for kanagawa_fifo_read_prefetch: queue-based FIFO/RAM model with a word-accounting scoreboard.
module tb_kanagawa_fifo_read_prefetch;

    localparam int WIDTH = 32;
    localparam int RL    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             rdreq_out;
    logic             empty_in;
    logic [WIDTH-1:0] rddata_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    occupancy;

    kanagawa_fifo_read_prefetch #(
        .WIDTH(WIDTH), .READ_LATENCY(RL), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rdreq_out(rdreq_out), .empty_in(empty_in),
        .rddata_in(rddata_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // FIFO contents, words read but not yet delivered, and the RAM return pipe
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    bit          dl_v[RL];
    logic [31:0] dl_d[RL];
    int          arrived, consumed, cyc, req_total, pop_total;
    int          push_left, push_pct, ready_pct;
    logic [31:0] next_word;
    bit          force_nonempty;
    bit          obs_rq, obs_vld, obs_pop;
    logic [31:0] obs_dat;

    task automatic drive_inputs();
        empty_in  = force_nonempty ? 1'b0 : (fifo_q.size() == 0);
        out_ready = ($urandom_range(99) < ready_pct);
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
        drive_inputs();
    endtask

    task automatic model_reset();
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < RL; i++) dl_v[i] = 1'b0;
        arrived   = 0;
        consumed  = 0;
        push_left = 0;
    endtask

    task automatic tick();
        int inflight, occ;
        bit rq, pp, arr;
        logic [31:0] w;
        @(negedge clk);
        occ = arrived - consumed;
        inflight = 0;
        for (int i = 0; i < RL; i++) inflight += int'(dl_v[i]);
        chk("rdreq", 32'(rdreq_out), 32'(rst && !empty_in && (inflight + occ < DEPTH)));
        chk("out_valid", 32'(out_valid), 32'(occ != 0));
        chk("occupancy", 32'(occupancy), 32'(occ));
        rq  = rdreq_out;
        pp  = out_valid && out_ready;
        arr = dl_v[RL-1];
        if (pp) begin
            if (exp_q.size() == 0) chk("pop_without_word", 32'd1, 32'd0);
            else chk("out_data", out_data, exp_q.pop_front());
            pop_total++;
        end
        if (rq) req_total++;
        obs_rq = rq; obs_vld = out_valid; obs_pop = pp; obs_dat = out_data;
        @(posedge clk);
        #1;
        cyc++;
        if (arr) arrived++;
        if (pp) consumed++;
        for (int i = RL - 1; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_d[i] = dl_d[i-1];
        end
        dl_v[0] = 1'b0;
        dl_d[0] = $urandom;
        if (rq && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            dl_v[0] = 1'b1;
            dl_d[0] = w;
            exp_q.push_back(w);
        end
        rddata_in = dl_d[RL-1];
        if (push_left > 0 && $urandom_range(99) < push_pct) begin
            fifo_q.push_back(next_word);
            next_word++;
            push_left--;
        end
        drive_inputs();
    endtask

    initial begin
        int nreq, nvld, t_req, t_vld, r0, p0, fr, lr, fp, lp, budget, infl;
        rst = 1'b0;
        cyc = 0; req_total = 0; pop_total = 0;
        push_pct = 0; ready_pct = 100; next_word = 0;
        model_reset();
        for (int i = 0; i < RL; i++) dl_d[i] = $urandom;
        rddata_in = 0;
        force_nonempty = 1'b1;
        drive_inputs();

        // Reset held with a non-empty FIFO: nothing may be requested or shown
        repeat (20) tick();
        force_nonempty = 1'b0;
        drive_inputs();
        rst = 1'b1;
        tick();

        // Single word
        fifo_q.push_back(32'hA5);
        drive_inputs();
        nreq = 0; nvld = 0; t_req = -1; t_vld = -1;
        repeat (12) begin
            tick();
            if (obs_rq) begin nreq++; if (t_req < 0) t_req = cyc; end
            if (obs_vld) begin
                nvld++;
                if (t_vld < 0) begin t_vld = cyc; chk("t2_data", obs_dat, 32'hA5); end
            end
        end
        chk("t2_nreq", 32'(nreq), 32'd1);
        chk("t2_nvld", 32'(nvld), 32'd1);
        chk("t2_latency", 32'(t_vld - t_req), 32'(RL + 1));

        // 100-word stream at full rate
        push_words(100, 32'd0);
        r0 = req_total; p0 = pop_total; fr = -1; lr = -1; fp = -1; lp = -1; budget = 0;
        while (pop_total - p0 < 100 && budget < 300) begin
            tick();
            budget++;
            if (obs_rq) begin if (fr < 0) fr = cyc; lr = cyc; end
            if (obs_pop) begin if (fp < 0) fp = cyc; lp = cyc; end
        end
        chk("t3_reqs", 32'(req_total - r0), 32'd100);
        chk("t3_pops", 32'(pop_total - p0), 32'd100);
        chk("t3_req_span", 32'(lr - fr), 32'd99);
        chk("t3_pop_span", 32'(lp - fp), 32'd99);

        // Stalled consumer: buffer fills to DEPTH, then drains
        ready_pct = 0;
        push_words(20, 32'h100);
        r0 = req_total;
        repeat (20) tick();
        chk("t4_reqs", 32'(req_total - r0), 32'(DEPTH));
        chk("t4_occ_sat", 32'(occupancy), 32'(DEPTH));
        ready_pct = 100;
        drive_inputs();
        p0 = pop_total; r0 = req_total;
        repeat (4) tick();
        chk("t4_first_pops", 32'(pop_total - p0), 32'(DEPTH));
        chk("t4_req_resumed", 32'(req_total - r0 > 0), 32'd1);
        budget = 0;
        while (pop_total - p0 < 20 && budget < 200) begin tick(); budget++; end
        chk("t4_drained", 32'(pop_total - p0), 32'd20);

        // Random producer and consumer
        push_left = 3000; next_word = 32'h10000; push_pct = 60; ready_pct = 70;
        p0 = pop_total; budget = 0;
        while (pop_total - p0 < 3000 && budget < 40000) begin tick(); budget++; end
        chk("t5_received", 32'(pop_total - p0), 32'd3000);

        // Reset with reads in flight; stale RAM returns must be ignored
        push_pct = 0; ready_pct = 100;
        push_words(10, 32'h2000);
        budget = 0;
        while (!(dl_v[0] && dl_v[RL-1]) && budget < 20) begin tick(); budget++; end
        infl = 0;
        for (int i = 0; i < RL; i++) infl += int'(dl_v[i]);
        chk("t6_inflight", 32'(infl), 32'(RL));
        rst = 1'b0;
        #1;
        chk("t6_valid_clr", 32'(out_valid), 32'd0);
        chk("t6_occ_clr", 32'(occupancy), 32'd0);
        chk("t6_rdreq_clr", 32'(rdreq_out), 32'd0);
        model_reset();
        drive_inputs();
        tick();
        rst = 1'b1;
        repeat (6) tick();
        push_words(5, 32'h3000);
        p0 = pop_total; budget = 0;
        while (pop_total - p0 < 5 && budget < 50) begin tick(); budget++; end
        chk("t6_after_reset", 32'(pop_total - p0), 32'd5);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
